keypad_scan: RTL



---
 rtl/keypad_scan_if.sv | 25 ++
 rtl/keypad_scan.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_if.sv
// Keypad pin bundle plus key-event outputs for the matrix keypad scanner.
// The scanner is the master: it drives the column strobes and key events and samples the rows.
interface keypad_scan_if;
  logic [3:0] row_in;     // active-low rows from the keypad
  logic [3:0] col_out;    // active-low column strobes
  logic [3:0] key_code;   // {column, row} of the accepted key
  logic       key_valid;  // one-cycle press event
  logic       key_held;   // accepted key still considered down

  modport master (
    input  row_in,
    output col_out,
    output key_code,
    output key_valid,
    output key_held
  );

  modport slave (
    output row_in,
    input  col_out,
    input  key_code,
    input  key_valid,
    input  key_held
  );
endinterface

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: rotates one active-low column strobe, synchronizes and samples the
// rows once per column dwell, and debounces whole frames into single-key press events.
module keypad_scan #(
  parameter int unsigned SCAN_DIV = 4096,  // cycles per column, >= 4
  parameter int unsigned DEBOUNCE = 3      // identical frames to accept press/release, 1..15
) (
  input  logic         clk,
  input  logic         rst_n,
  keypad_scan_if.master kp
);

  localparam int unsigned    DivW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);
  localparam logic [3:0]      DebLast = 4'(DEBOUNCE);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StPressDb = 2'd1;
  localparam logic [1:0] StPressed = 2'd2;
  localparam logic [1:0] StRelDb   = 2'd3;

  logic [DivW-1:0] div_q, div_d;
  logic [1:0]      col_idx_q, col_idx_d;
  logic [3:0]      sync1_q, sync2_q;
  logic [15:0]     snap_q, snap_d;
  logic            eval_q, eval_d;
  logic [1:0]      state_q, state_d;
  logic [3:0]      cand_q, cand_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [3:0]      key_code_q, key_code_d;
  logic            key_valid_q, key_valid_d;

  logic            dwell_end;
  logic            any_bit;
  logic            multi_bit;
  logic            one_hot;
  logic [3:0]      one_code;
  logic            cand_hit;
  logic [3:0]      cnt_inc;

  assign dwell_end = (div_q == DivLast);

  // Dwell counter, column rotation and per-column row snapshot.
  always_comb begin
    div_d     = dwell_end ? '0 : div_q + DivW'(1);
    col_idx_d = dwell_end ? col_idx_q + 2'd1 : col_idx_q;
    snap_d    = snap_q;
    if (dwell_end) begin
      unique case (col_idx_q)
        2'd0: snap_d[3:0]   = ~sync2_q;
        2'd1: snap_d[7:4]   = ~sync2_q;
        2'd2: snap_d[11:8]  = ~sync2_q;
        2'd3: snap_d[15:12] = ~sync2_q;
        default: snap_d = snap_q;
      endcase
    end
    // The frame is complete once column 3 has been sampled; evaluate it next cycle.
    eval_d = dwell_end && (col_idx_q == 2'd3);
  end

  // Column strobe decode: exactly one active-low strobe.
  always_comb begin
    kp.col_out = 4'b0111;
    unique case (col_idx_q)
      2'd0: kp.col_out = 4'b0111;
      2'd1: kp.col_out = 4'b1011;
      2'd2: kp.col_out = 4'b1101;
      2'd3: kp.col_out = 4'b1110;
      default: kp.col_out = 4'b0111;
    endcase
  end

  // Frame classification: none / exactly one key / several keys.
  always_comb begin
    any_bit   = |snap_q;
    multi_bit = |(snap_q & (snap_q - 16'd1));
    one_hot   = any_bit && !multi_bit;
    one_code  = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (snap_q[i]) one_code = 4'(i);
    end
    cand_hit = snap_q[cand_q];
    cnt_inc  = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
  end

  // Debounce FSM, advanced only in the frame evaluation cycle.
  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    if (eval_q) begin
      unique case (state_q)
        StIdle: begin
          if (one_hot) begin
            cand_d = one_code;
            cnt_d  = 4'd1;
            if (DEBOUNCE <= 1) begin
              state_d     = StPressed;
              key_valid_d = 1'b1;
              key_code_d  = one_code;
            end else begin
              state_d = StPressDb;
            end
          end
        end
        StPressDb: begin
          if (one_hot && (one_code == cand_q)) begin
            cnt_d = cnt_inc;
            if (cnt_inc >= DebLast) begin
              state_d     = StPressed;
              key_valid_d = 1'b1;
              key_code_d  = cand_q;
            end
          end else if (one_hot) begin
            cand_d = one_code;
            cnt_d  = 4'd1;
          end else begin
            state_d = StIdle;
          end
        end
        StPressed: begin
          // Extra keys are ignored while the accepted key stays down.
          if (!cand_hit) begin
            cnt_d   = 4'd1;
            state_d = (DEBOUNCE <= 1) ? StIdle : StRelDb;
          end
        end
        StRelDb: begin
          if (cand_hit) begin
            state_d = StPressed;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc >= DebLast) state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Scan timing and snapshot state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q     <= '0;
      col_idx_q <= 2'd0;
      snap_q    <= 16'd0;
      eval_q    <= 1'b0;
    end else begin
      div_q     <= div_d;
      col_idx_q <= col_idx_d;
      snap_q    <= snap_d;
      eval_q    <= eval_d;
    end
  end

  // Two-flop synchronizer for the asynchronous row inputs; idles at "no key".
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 4'hF;
      sync2_q <= 4'hF;
    end else begin
      sync1_q <= kp.row_in;
      sync2_q <= sync1_q;
    end
  end

  // Debounce state and key event registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cand_q      <= 4'd0;
      cnt_q       <= 4'd0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
    end
  end

  assign kp.key_code  = key_code_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_held  = (state_q == StPressed) || (state_q == StRelDb);

endmodule
